// File: rtl/stream_arb_2x1_pkg.sv
// rtl/stream_arb_2x1_pkg.sv - shared constants and lock FSM encoding for stream_arb_2x1
package stream_arb_2x1_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } lock_state_t;

endpackage

// File: rtl/arb_rr_2.sv
// rtl/arb_rr_2.sv - combinational two-way round-robin grant with packet lock override
module arb_rr_2
  import stream_arb_2x1_pkg::*;
(
  input  logic        a_valid,
  input  logic        b_valid,
  input  logic        last,
  input  logic        load,
  input  lock_state_t lock_state,
  output logic        grant_a,
  output logic        grant_b
);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (load) begin
      case (lock_state)
        ST_LOCK_A: grant_a = a_valid;
        ST_LOCK_B: grant_b = b_valid;
        default: begin
          // On a tie the source that did not win last time goes next
          if (a_valid && b_valid) begin
            grant_a = (last == SRC_B);
            grant_b = (last == SRC_A);
          end else begin
            grant_a = a_valid;
            grant_b = b_valid;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/stream_arb_2x1.sv
// rtl/stream_arb_2x1.sv - 2:1 round-robin stream arbiter with registered output stage
// Optional packet locking enabled by defining ARB_PKT_LOCK_EN.
module stream_arb_2x1
  import stream_arb_2x1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  input  logic             out_ready
`ifdef ARB_PKT_LOCK_EN
  ,
  input  logic             a_last,
  input  logic             b_last,
  output logic             out_last
`endif
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_sel;
  logic             r_last;

  logic        w_load;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_xfer_a;
  logic        w_xfer_b;
  logic        w_xfer;
  logic        w_win;
  logic        w_ptr_upd;
  lock_state_t w_lock_state;

  assign w_load   = !r_out_valid || out_ready;
  assign a_ready  = rst_n && w_grant_a;
  assign b_ready  = rst_n && w_grant_b;
  assign w_xfer_a = a_valid && a_ready;
  assign w_xfer_b = b_valid && b_ready;
  assign w_xfer   = w_xfer_a || w_xfer_b;
  assign w_win    = w_xfer_b ? SRC_B : SRC_A;

  arb_rr_2 u_arb (
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last       (r_last),
    .load       (w_load),
    .lock_state (w_lock_state),
    .grant_a    (w_grant_a),
    .grant_b    (w_grant_b)
  );

`ifdef ARB_PKT_LOCK_EN
  lock_state_t r_state;
  lock_state_t w_state_nxt;
  logic        r_out_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer_a && !a_last) begin
          w_state_nxt = ST_LOCK_A;
        end else if (w_xfer_b && !b_last) begin
          w_state_nxt = ST_LOCK_B;
        end
      end
      ST_LOCK_A: if (w_xfer_a && a_last) w_state_nxt = ST_IDLE;
      ST_LOCK_B: if (w_xfer_b && b_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_out_last <= w_xfer_b ? b_last : a_last;
    end
  end

  assign w_lock_state = r_state;
  // Pointer moves once per packet: only beats arbitrated from IDLE touch it
  assign w_ptr_upd    = (r_state == ST_IDLE);
  assign out_last     = r_out_last;
`else
  assign w_lock_state = ST_IDLE;
  assign w_ptr_upd    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel       <= SRC_A;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_xfer_b ? b_data : a_data;
      r_sel       <= w_win;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= SRC_B;
    end else if (w_xfer && w_ptr_upd) begin
      r_last <= w_win;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;

endmodule

// File: doc/stream_arb_2x1.md
Name: stream_arb_2x1

Overview:
- Two-input round-robin stream arbiter with a one-entry registered output stage.
- Sits directly upstream of the 2:1 select datapath. It decides which source wins, registers the winning word, and drives the registered select bit `sel` (0 = A, 1 = B) consumed by the muxing stage.
- Valid/ready handshake on both inputs and on the output.

Parameters:
- WIDTH, 8, data width of each input and of the output word.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- a_valid  input  1  source A presents a word.
- a_data  input  WIDTH  source A word.
- a_ready  output  1  source A word accepted this cycle.
- b_valid  input  1  source B presents a word.
- b_data  input  WIDTH  source B word.
- b_ready  output  1  source B word accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered winning word.
- sel  output  1  registered source of out_data (0 = A, 1 = B).
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_data=0, sel=0.
  - Round-robin pointer last=B, so A wins the first tie.
  - a_ready=b_ready=0 while rst_n=0.
  - Reset mid-operation discards any held word; no handshake completes in that cycle.
- Load condition: load = !out_valid | out_ready, i.e. the register is empty or being drained this cycle.
- Grant (combinational):
  - only a_valid -> A; only b_valid -> B.
  - both valid -> the source not equal to last.
  - neither valid -> none.
- Ready outputs:
  - a_ready = load & grant_A; b_ready = load & grant_B.
  - At most one ready is high per cycle.
  - Ready may depend on valid; sources must not make valid depend on ready.
- Transfer into the register (a_valid&a_ready or b_valid&b_ready), at the next edge:
  - out_data <= winner data, sel <= winner id, out_valid <= 1.
  - last <= winner.
- Drain with no new load (out_ready & out_valid & no grant): out_valid <= 0; out_data and sel hold.
- Simultaneous drain and load in the same cycle: the new word replaces the old one with no bubble. Full throughput is 1 word/cycle.
- Latency: input handshake to out_valid is 1 cycle.
- Stall (out_valid & !out_ready):
  - out_data and sel stable.
  - both readies 0.
  - pointer frozen.
- Fairness: with both sources continuously valid and out_ready=1, grants alternate A,B,A,B…
- The pointer updates only on an actual transfer, never on an idle or stalled cycle.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined:
  - Adds inputs a_last and b_last (1 bit each) and output out_last (registered alongside out_data, reset 0).
  - Adds 3-state FSM IDLE / LOCK_A / LOCK_B, reset state IDLE.
  - IDLE -> LOCK_x on a transfer from x with x_last=0.
  - In LOCK_x only x may be granted, even if the other source is valid and x is not. Round-robin is suspended.
  - LOCK_x -> IDLE on a transfer from x with x_last=1.
  - The pointer updates only on the IDLE entry/exit transfer, i.e. per packet.
- Undefined: every beat is arbitrated independently; no last ports and no FSM.

Decomposition:
- Shared package: SRC_A=1'b0 and SRC_B=1'b1 constants, lock FSM state encoding (IDLE=2'd0, LOCK_A=2'd1, LOCK_B=2'd2), default WIDTH.
- One natural sub-module, arb_rr_2: purely combinational grant plus pointer-next logic (inputs: valids, last, load, lock state; outputs: grant_a, grant_b).
- The output register and FSM stay in the top module.

Test Plan:
- Reset mid-stall: out_valid=1, assert rst_n=0 for one cycle -> out_valid=0, sel=0, out_data=0 next cycle; first subsequent tie goes to A.
- A only, a_data=8'h3C, out_ready=1 -> a_ready=1 same cycle; next cycle out_valid=1, out_data=8'h3C, sel=0.
- Both valid continuously (A=8'h11, B=8'h22), out_ready=1 for 4 cycles -> outputs 11,22,11,22 with sel 0,1,0,1; one word every cycle, no bubbles.
- Backpressure: out_ready=0 for 3 cycles while both valid -> out_data and sel held, a_ready=b_ready=0, pointer unchanged. Release -> the next grant goes to the source not just granted.
- Drain without refill: out_valid=1, out_ready=1, no valids -> out_valid=0 next cycle, out_data held.
- ARB_PKT_LOCK_EN: A sends a 3-beat packet (last on beat 3) while B stays valid, with A valid dropped for one cycle mid-packet -> B is never granted until A's last beat transfers, then B is granted next.
